result_writeback_nn: RTL and testbench

- Downstream consumer of the 2x2 MAC array / top sequencer in the NxN matrix-vector path.
- Captures the four accumulator outputs each time a row tile completes, reduces partial-sum pairs into two row results, and requantizes them to W bits (shift, optional ReLU, saturate).
- Holds N results in a register buffer; after the sequencer's done, streams them out over a valid/ready interface.

---
 rtl/result_writeback_nn.sv | 225 ++++++++++++++++++++++
 tb/tb_result_writeback_nn.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/result_writeback_nn.sv
// result_writeback_nn
//
// Purpose:
//   Sits behind the 2x2 MAC array / top sequencer of the NxN matrix-vector
//   path. Each time a row tile completes, the four accumulator outputs are
//   captured. They are reduced pairwise into two row sums, and each sum is
//   requantized to W bits (arithmetic shift, optional ReLU, saturation).
//   The results are stored in an N-entry buffer. After the sequencer's done
//   pulse the buffer is streamed out over a valid/ready interface.
//
// Ports:
//   clk            clock, rising edge
//   rst            asynchronous reset, active low
//   start          one-cycle pulse, arms collection and clears the buffer
//   acc_in_0..3    signed MAC accumulator outputs (ACC_W bits each)
//   valid_in       per-MAC valid; all four must be set for a capture
//   row_tile       tile index of the current results (entries 2t, 2t+1)
//   done_in        sequencer done pulse, starts the drain
//   out_valid      stream data valid
//   out_ready      stream consumer ready
//   out_data       requantized result (signed, W bits)
//   out_index      row index of out_data
//   out_last       high together with entry N-1
//   busy           block is collecting or draining
//   wb_done        one-cycle pulse after the last beat is accepted
//   err_partial    sticky: valid_in was seen neither 0 nor all ones
//   err_missing    sticky: done_in arrived before every tile was captured
module result_writeback_nn #(
    parameter int W     = 8,
    parameter int ACC_W = 16,
    parameter int N     = 4,
    parameter int SHIFT = 0,
    parameter int RELU  = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic signed [ACC_W-1:0]       acc_in_0,
    input  logic signed [ACC_W-1:0]       acc_in_1,
    input  logic signed [ACC_W-1:0]       acc_in_2,
    input  logic signed [ACC_W-1:0]       acc_in_3,
    input  logic [3:0]                    valid_in,
    input  logic [$clog2(N/2)-1:0]        row_tile,
    input  logic                          done_in,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic signed [W-1:0]           out_data,
    output logic [$clog2(N)-1:0]          out_index,
    output logic                          out_last,
    output logic                          busy,
    output logic                          wb_done,
    output logic                          err_partial,
    output logic                          err_missing
);

    localparam int TW   = $clog2(N/2);
    localparam int IW   = $clog2(N);
    localparam int MAXI = 2**(W-1) - 1;
    localparam int MINI = -(2**(W-1));
    localparam logic signed [ACC_W:0] MAX_V = MAXI[ACC_W:0];
    localparam logic signed [ACC_W:0] MIN_V = MINI[ACC_W:0];
    localparam logic [IW-1:0]         LAST_IDX = IW'(N-1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DRAIN   = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic signed [W-1:0]    entry_q [N];
    logic signed [W-1:0]    entry_d [N];
    logic [N/2-1:0]         tileSeen_q, tileSeen_d;
    logic [IW-1:0]          idx_q, idx_d, idxNext;
    logic                   outValid_q, outValid_d;
    logic signed [W-1:0]    outData_q, outData_d;
    logic                   outLast_q, outLast_d;
    logic                   wbDone_q, wbDone_d;
    logic                   errPartial_q, errPartial_d;
    logic                   errMissing_q, errMissing_d;

    logic signed [ACC_W:0]  sumA, sumB;
    logic signed [W-1:0]    qA, qB;

    // Shift, optional ReLU, then clamp into the signed W-bit range.
    function automatic logic signed [W-1:0] requant(input logic signed [ACC_W:0] s);
        logic signed [ACC_W:0] sh;
        sh = s >>> SHIFT;
        if ((RELU != 0) && sh[ACC_W]) begin
            sh = '0;
        end
        if (sh > MAX_V) begin
            return MAX_V[W-1:0];
        end else if (sh < MIN_V) begin
            return MIN_V[W-1:0];
        end
        return sh[W-1:0];
    endfunction

    // Sums are one bit wider than the accumulators so they never wrap.
    assign sumA = {acc_in_0[ACC_W-1], acc_in_0} + {acc_in_1[ACC_W-1], acc_in_1};
    assign sumB = {acc_in_2[ACC_W-1], acc_in_2} + {acc_in_3[ACC_W-1], acc_in_3};
    assign qA   = requant(sumA);
    assign qB   = requant(sumB);

    assign idxNext = idx_q + 1'b1;

    // Next-state logic. The buffer next-state is computed before the drain
    // decision, so a capture arriving with done_in is visible to both the
    // tile_seen check and the first beat.
    always_comb begin
        state_d      = state_q;
        entry_d      = entry_q;
        tileSeen_d   = tileSeen_q;
        idx_d        = idx_q;
        outValid_d   = outValid_q;
        outData_d    = outData_q;
        outLast_d    = outLast_q;
        wbDone_d     = 1'b0;
        errPartial_d = errPartial_q;
        errMissing_d = errMissing_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    for (int i = 0; i < N; i++) begin
                        entry_d[i] = '0;
                    end
                    tileSeen_d   = '0;
                    errPartial_d = 1'b0;
                    errMissing_d = 1'b0;
                    state_d      = COLLECT;
                end
            end
            COLLECT: begin
                if (start) begin
                    for (int i = 0; i < N; i++) begin
                        entry_d[i] = '0;
                    end
                    tileSeen_d   = '0;
                    errPartial_d = 1'b0;
                    errMissing_d = 1'b0;
                end else begin
                    if (valid_in == 4'b1111) begin
                        for (int t = 0; t < N/2; t++) begin
                            if (row_tile == TW'(t)) begin
                                entry_d[2*t]   = qA;
                                entry_d[2*t+1] = qB;
                                tileSeen_d[t]  = 1'b1;
                            end
                        end
                    end else if (valid_in != 4'b0000) begin
                        errPartial_d = 1'b1;
                    end
                    if (done_in) begin
                        if (!(&tileSeen_d)) begin
                            errMissing_d = 1'b1;
                        end
                        state_d    = DRAIN;
                        idx_d      = '0;
                        outValid_d = 1'b1;
                        outData_d  = entry_d[0];
                        outLast_d  = 1'b0;
                    end
                end
            end
            DRAIN: begin
                if (outValid_q && out_ready) begin
                    if (idx_q == LAST_IDX) begin
                        outValid_d = 1'b0;
                        outLast_d  = 1'b0;
                        wbDone_d   = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        idx_d     = idxNext;
                        outData_d = entry_q[idxNext];
                        outLast_d = (idxNext == LAST_IDX);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers, all cleared by the asynchronous reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            for (int i = 0; i < N; i++) begin
                entry_q[i] <= '0;
            end
            tileSeen_q   <= '0;
            idx_q        <= '0;
            outValid_q   <= 1'b0;
            outData_q    <= '0;
            outLast_q    <= 1'b0;
            wbDone_q     <= 1'b0;
            errPartial_q <= 1'b0;
            errMissing_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            entry_q      <= entry_d;
            tileSeen_q   <= tileSeen_d;
            idx_q        <= idx_d;
            outValid_q   <= outValid_d;
            outData_q    <= outData_d;
            outLast_q    <= outLast_d;
            wbDone_q     <= wbDone_d;
            errPartial_q <= errPartial_d;
            errMissing_q <= errMissing_d;
        end
    end

    assign out_valid   = outValid_q;
    assign out_data    = outData_q;
    assign out_index   = idx_q;
    assign out_last    = outLast_q;
    assign busy        = (state_q != IDLE);
    assign wb_done     = wbDone_q;
    assign err_partial = errPartial_q;
    assign err_missing = errMissing_q;

endmodule

// File: tb/tb_result_writeback_nn.sv
// tb_result_writeback_nn
//
// Purpose:
//   Self-checking bench for result_writeback_nn. Two instances share all
//   inputs: dutA uses SHIFT=2, RELU=1 and dutB uses SHIFT=0, RELU=0.
//   Each table record holds the accumulator values of both row tiles and
//   the hand-computed stream expected from each instance. Hand-written
//   sequences cover stall, error flags, reset mid-drain, and a capture
//   arriving together with done_in.
module tb_result_writeback_nn;

    logic               clk;
    logic               rst;
    logic               start;
    logic signed [15:0] acc0, acc1, acc2, acc3;
    logic [3:0]         validIn;
    logic [0:0]         rowTile;
    logic               doneIn;
    logic               outReady;

    logic               outValidA, outLastA, busyA, wbDoneA, errPartialA, errMissingA;
    logic signed [7:0]  outDataA;
    logic [1:0]         outIndexA;
    logic               outValidB, outLastB, busyB, wbDoneB, errPartialB, errMissingB;
    logic signed [7:0]  outDataB;
    logic [1:0]         outIndexB;

    int vectors    = 0;
    int miscompares = 0;

    result_writeback_nn #(.W(8), .ACC_W(16), .N(4), .SHIFT(2), .RELU(1)) dutA (
        .clk(clk), .rst(rst), .start(start),
        .acc_in_0(acc0), .acc_in_1(acc1), .acc_in_2(acc2), .acc_in_3(acc3),
        .valid_in(validIn), .row_tile(rowTile), .done_in(doneIn),
        .out_valid(outValidA), .out_ready(outReady), .out_data(outDataA),
        .out_index(outIndexA), .out_last(outLastA), .busy(busyA),
        .wb_done(wbDoneA), .err_partial(errPartialA), .err_missing(errMissingA)
    );

    result_writeback_nn #(.W(8), .ACC_W(16), .N(4), .SHIFT(0), .RELU(0)) dutB (
        .clk(clk), .rst(rst), .start(start),
        .acc_in_0(acc0), .acc_in_1(acc1), .acc_in_2(acc2), .acc_in_3(acc3),
        .valid_in(validIn), .row_tile(rowTile), .done_in(doneIn),
        .out_valid(outValidB), .out_ready(outReady), .out_data(outDataB),
        .out_index(outIndexB), .out_last(outLastB), .busy(busyB),
        .wb_done(wbDoneB), .err_partial(errPartialB), .err_missing(errMissingB)
    );

    // acc[0..3] belong to tile 0, acc[4..7] to tile 1.
    typedef struct packed {
        logic [7:0][15:0] acc;
        logic [3:0][7:0]  expA;
        logic [3:0][7:0]  expB;
    } vec_t;

    localparam int NUM_TABLE = 4;
    vec_t vecs [5];

    function automatic vec_t mkVec(
        input int t0a0, input int t0a1, input int t0a2, input int t0a3,
        input int t1a0, input int t1a1, input int t1a2, input int t1a3,
        input int a0, input int a1, input int a2, input int a3,
        input int b0, input int b1, input int b2, input int b3);
        vec_t v;
        v.acc[0] = t0a0[15:0]; v.acc[1] = t0a1[15:0];
        v.acc[2] = t0a2[15:0]; v.acc[3] = t0a3[15:0];
        v.acc[4] = t1a0[15:0]; v.acc[5] = t1a1[15:0];
        v.acc[6] = t1a2[15:0]; v.acc[7] = t1a3[15:0];
        v.expA[0] = a0[7:0]; v.expA[1] = a1[7:0];
        v.expA[2] = a2[7:0]; v.expA[3] = a3[7:0];
        v.expB[0] = b0[7:0]; v.expB[1] = b1[7:0];
        v.expB[2] = b2[7:0]; v.expB[3] = b3[7:0];
        return v;
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic signed [31:0] act,
                               input logic signed [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic setTile(input int vi, input int tile, input logic [3:0] vld);
        acc0    = vecs[vi].acc[tile*4+0];
        acc1    = vecs[vi].acc[tile*4+1];
        acc2    = vecs[vi].acc[tile*4+2];
        acc3    = vecs[vi].acc[tile*4+3];
        rowTile = tile[0:0];
        validIn = vld;
    endtask

    // mode 0: tile0, tile1, then done alone
    // mode 1: tile0, then tile1 together with done
    // mode 2: tile1, then tile0 together with done
    task automatic applyStimulus(input int vi, input int mode);
        start = 1'b1;
        tick();
        start = 1'b0;
        case (mode)
            0: begin
                setTile(vi, 0, 4'b1111); tick();
                setTile(vi, 1, 4'b1111); tick();
                validIn = 4'b0000;
                doneIn  = 1'b1; tick();
            end
            1: begin
                setTile(vi, 0, 4'b1111); tick();
                setTile(vi, 1, 4'b1111);
                doneIn = 1'b1; tick();
            end
            default: begin
                setTile(vi, 1, 4'b1111); tick();
                setTile(vi, 0, 4'b1111);
                doneIn = 1'b1; tick();
            end
        endcase
        doneIn  = 1'b0;
        validIn = 4'b0000;
    endtask

    // Walks the stream; the beat numbered stallBeat is presented four cycles.
    task automatic drainCheck(input int vi, input int stallBeat);
        int reps;
        for (int b = 0; b < 4; b++) begin
            reps = (b == stallBeat) ? 4 : 1;
            for (int r = 0; r < reps; r++) begin
                outReady = (r == reps - 1);
                checkOutput($sformatf("validA[%0d]", b), 32'(outValidA), 1);
                checkOutput($sformatf("dataA[%0d]", b), 32'(outDataA), 32'($signed(vecs[vi].expA[b])));
                checkOutput($sformatf("indexA[%0d]", b), 32'(outIndexA), b);
                checkOutput($sformatf("lastA[%0d]", b), 32'(outLastA), (b == 3) ? 1 : 0);
                checkOutput($sformatf("dataB[%0d]", b), 32'(outDataB), 32'($signed(vecs[vi].expB[b])));
                checkOutput($sformatf("indexB[%0d]", b), 32'(outIndexB), b);
                tick();
            end
        end
        checkOutput("validA after last", 32'(outValidA), 0);
        checkOutput("wbDoneA pulse", 32'(wbDoneA), 1);
        checkOutput("wbDoneB pulse", 32'(wbDoneB), 1);
        checkOutput("busyA after last", 32'(busyA), 0);
        tick();
        checkOutput("wbDoneA one cycle", 32'(wbDoneA), 0);
        checkOutput("validA idle", 32'(outValidA), 0);
    endtask

    initial begin
        vecs[0] = mkVec(100, 20, -8, 4,   40, 0, 600, 0,
                        30, 0, 10, 127,    120, -4, 40, 127);
        vecs[1] = mkVec(-500, -500, 32767, 32767,   0, 0, -2, 1,
                        0, 127, 0, 0,      -128, 127, 0, -1);
        vecs[2] = mkVec(-32768, -32768, 200, -73,   -3, -4, 255, 1,
                        0, 31, 0, 64,      -128, 127, -7, 127);
        vecs[3] = mkVec(508, 3, -129, 0,   1, 2, 7, -2,
                        127, 0, 0, 1,      127, -128, 3, 5);
        // tile0 rejected as partial, only tile1 lands
        vecs[4] = mkVec(100, 20, -8, 4,   40, 0, 600, 0,
                        0, 0, 10, 127,     0, 0, 40, 127);

        rst = 1'b0; start = 1'b0; doneIn = 1'b0; outReady = 1'b1;
        acc0 = '0; acc1 = '0; acc2 = '0; acc3 = '0;
        validIn = 4'b0000; rowTile = '0;
        #12;
        checkOutput("reset validA", 32'(outValidA), 0);
        checkOutput("reset dataA", 32'(outDataA), 0);
        checkOutput("reset busyA", 32'(busyA), 0);
        checkOutput("reset errPartialA", 32'(errPartialA), 0);
        checkOutput("reset errMissingA", 32'(errMissingA), 0);
        rst = 1'b1;
        tick();

        // Inputs in IDLE are ignored.
        setTile(0, 0, 4'b0011);
        doneIn = 1'b1;
        tick();
        doneIn = 1'b0; validIn = 4'b0000;
        tick();
        checkOutput("idle ignores done", 32'(busyA), 0);
        checkOutput("idle ignores partial", 32'(errPartialA), 0);

        // Table: full capture and drain with ready held high.
        for (int v = 0; v < NUM_TABLE; v++) begin
            applyStimulus(v, 0);
            checkOutput($sformatf("busyA vec%0d", v), 32'(busyA), 1);
            checkOutput($sformatf("errPartialA vec%0d", v), 32'(errPartialA), 0);
            checkOutput($sformatf("errMissingA vec%0d", v), 32'(errMissingA), 0);
            drainCheck(v, -1);
        end

        // Stall: idx1 held for four cycles.
        applyStimulus(0, 0);
        drainCheck(0, 1);

        // Capture together with done_in.
        applyStimulus(0, 1);
        checkOutput("errMissing tile1+done", 32'(errMissingA), 0);
        drainCheck(0, -1);
        applyStimulus(0, 2);
        checkOutput("errMissing tile0+done", 32'(errMissingA), 0);
        drainCheck(0, -1);

        // Partial valid on tile0, missing tile0 at done.
        start = 1'b1; tick(); start = 1'b0;
        setTile(4, 0, 4'b0011); tick();
        setTile(4, 1, 4'b1111); tick();
        validIn = 4'b0000; doneIn = 1'b1; tick();
        doneIn = 1'b0;
        checkOutput("errPartialA set", 32'(errPartialA), 1);
        checkOutput("errMissingA set", 32'(errMissingA), 1);
        checkOutput("errMissingB set", 32'(errMissingB), 1);
        drainCheck(4, -1);
        checkOutput("errPartialA held", 32'(errPartialA), 1);
        checkOutput("errMissingA held", 32'(errMissingA), 1);
        start = 1'b1; tick(); start = 1'b0;
        checkOutput("errPartialA cleared", 32'(errPartialA), 0);
        checkOutput("errMissingA cleared", 32'(errMissingA), 0);

        // Restart from COLLECT, then reset while idx2 is presented.
        applyStimulus(0, 0);
        outReady = 1'b1;
        tick();
        tick();
        checkOutput("pre-reset indexA", 32'(outIndexA), 2);
        checkOutput("pre-reset dataA", 32'(outDataA), 10);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("async reset validA", 32'(outValidA), 0);
        checkOutput("async reset busyA", 32'(busyA), 0);
        checkOutput("async reset indexA", 32'(outIndexA), 0);
        checkOutput("async reset errPartialA", 32'(errPartialA), 0);
        tick();
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            checkOutput($sformatf("post-reset validA c%0d", c), 32'(outValidA), 0);
            checkOutput($sformatf("post-reset busyA c%0d", c), 32'(busyA), 0);
        end

        // A new start after reset works normally.
        applyStimulus(1, 0);
        drainCheck(1, -1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
